// File: rtl/mpsoc_ahb3_spram_ws_pkg.sv
// mpsoc_ahb3_spram_ws_pkg: AHB3 bus constants, slave FSM states and byte-enable helper
// Shared by the single-port scratchpad slave, its bus interface and benches.
package mpsoc_ahb3_spram_ws_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;
   localparam logic [2:0] HSIZE_B128  = 3'b100;
   localparam logic [2:0] HSIZE_B256  = 3'b101;
   localparam logic [2:0] HSIZE_B512  = 3'b110;
   localparam logic [2:0] HSIZE_B1024 = 3'b111;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;

   // Byte lanes touched by a transfer of 2**hsize bytes at haddr on a bus
   // be_size bytes wide; the result is sized for the widest (1024-bit) bus.
   function automatic logic [127:0] gen_be(input logic [2:0] hsize, input logic [6:0] haddr,
                                           input int unsigned be_size);
      logic [127:0] mask;
      logic [6:0]   off;
      mask = hsize == 3'd7 ? '1 : (128'd1 << (8'd1 << hsize)) - 128'd1;
      off  = haddr & 7'(be_size - 1) & ~((7'd1 << hsize) - 7'd1);
      return mask << off;
   endfunction
endpackage

// File: rtl/mpsoc_ahb3_spram_ws_if.sv
// mpsoc_ahb3_spram_ws_if: AHB-Lite slave-port bundle
// master drives address/control/write data; slave returns HRDATA, HREADYOUT, HRESP.
interface mpsoc_ahb3_spram_ws_if #(
   parameter int HADDR_SIZE = 64,
   parameter int HDATA_SIZE = 32
);
   logic                  HSEL;
   logic [HADDR_SIZE-1:0] HADDR;
   logic [HDATA_SIZE-1:0] HWDATA;
   logic [HDATA_SIZE-1:0] HRDATA;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [1:0]            HTRANS;
   logic                  HMASTLOCK;
   logic                  HREADY;
   logic                  HREADYOUT;
   logic                  HRESP;

   modport master(output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
                  input HRDATA, HREADYOUT, HRESP);
   modport slave(input HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
                 output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/mpsoc_ahb3_spram_ws_ram_1rw.sv
// mpsoc_ram_1rw: single-port RAM with byte enables and registered read data
// clk_i clock; addr_i word address; we_i/be_i/din_i byte-masked write;
// re_i read strobe; dout_o loaded one cycle after re_i and held otherwise.
module mpsoc_ram_1rw #(
   parameter int    ABITS      = 8,
   parameter int    DEPTH      = 256,
   parameter int    DBITS      = 32,
   parameter string TECHNOLOGY = "GENERIC"
) (
   input  logic               clk_i,
   input  logic [ABITS-1:0]   addr_i,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [DBITS/8-1:0] be_i,
   input  logic [DBITS-1:0]   din_i,
   output logic [DBITS-1:0]   dout_o
);
   logic [DBITS-1:0] mem [DEPTH];

   always_ff @(posedge clk_i)
      if (re_i) dout_o <= mem[addr_i];

   // GENERIC writes per byte lane; other technologies use a masked
   // whole-word write, the form FPGA/macro flows map onto byte-write RAMs.
   if (TECHNOLOGY == "GENERIC") begin : g_generic
      always_ff @(posedge clk_i)
         for (int i = 0; i < DBITS/8; i++)
            if (we_i && be_i[i]) mem[addr_i][i*8 +: 8] <= din_i[i*8 +: 8];
   end else begin : g_masked
      logic [DBITS-1:0] bmask;
      always_comb
         for (int i = 0; i < DBITS/8; i++) bmask[i*8 +: 8] = {8{be_i[i]}};
      always_ff @(posedge clk_i)
         if (we_i) mem[addr_i] <= (mem[addr_i] & ~bmask) | (din_i & bmask);
   end
endmodule

// File: rtl/mpsoc_ahb3_spram_ws.sv
// mpsoc_ahb3_spram_ws: AHB-Lite slave on a single-port SRAM with programmable wait states
// HCLK clock; HRESETn async active-low reset; ahb slave port (HSEL..HREADY in,
// HRDATA/HREADYOUT/HRESP out). Bad address/size/alignment gives a 2-cycle ERROR.
module mpsoc_ahb3_spram_ws
   import mpsoc_ahb3_spram_ws_pkg::*;
#(
   parameter int    MEM_SIZE    = 0,
   parameter int    MEM_DEPTH   = 256,
   parameter int    HADDR_SIZE  = 64,
   parameter int    HDATA_SIZE  = 32,
   parameter int    WAIT_STATES = 0,
   parameter string TECHNOLOGY  = "GENERIC"
) (
   input logic HCLK,
   input logic HRESETn,
   mpsoc_ahb3_spram_ws_if.slave ahb
);
   localparam int BE_SIZE = HDATA_SIZE / 8;
   localparam int BL      = $clog2(BE_SIZE);
   localparam int DEPTH   = MEM_DEPTH > 8*MEM_SIZE/HDATA_SIZE ? MEM_DEPTH : 8*MEM_SIZE/HDATA_SIZE;
   localparam int AW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [HADDR_SIZE:0] LIM = (HADDR_SIZE+1)'(DEPTH*BE_SIZE);

   state_t                state;
   logic [4:0]            cnt;
   logic [AW-1:0]         addr_r;
   logic                  we_r;
   logic [BE_SIZE-1:0]    be_r;
   logic                  hreadyout;
   logic                  hresp;
   logic [HDATA_SIZE-1:0] hrdata_q;
   logic [HDATA_SIZE-1:0] ram_dout;
   logic                  acc;
   logic                  err;
   logic [4:0]            load;
   logic                  ram_we;
   logic                  ram_re;
   logic                  unused_ok;

   assign acc = ahb.HSEL && ahb.HREADY && (ahb.HTRANS == HTRANS_NONSEQ || ahb.HTRANS == HTRANS_SEQ)
                && state inside {ST_IDLE, ST_LAST, ST_ERR2};
   assign err = {1'b0, ahb.HADDR} >= LIM || ahb.HSIZE > 3'(BL)
                || (ahb.HADDR[6:0] & 7'((8'd1 << ahb.HSIZE) - 8'd1)) != 7'd0;
   assign load = 5'(WAIT_STATES) + {4'd0, !ahb.HWRITE};

   // Writes land only in LAST and reads are issued only in WAIT, so the
   // single port never sees both in one cycle.
   assign ram_we = state == ST_LAST && we_r;
   assign ram_re = state == ST_WAIT && cnt == 5'd1 && !we_r;

   assign ahb.HREADYOUT = hreadyout;
   assign ahb.HRESP     = hresp;
   // The RAM output register carries fresh data during LAST; hrdata_q keeps it afterwards.
   assign ahb.HRDATA    = state == ST_LAST && !we_r ? ram_dout : hrdata_q;
   assign unused_ok     = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK};

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         addr_r    <= '0;
         we_r      <= 1'b0;
         be_r      <= '0;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         hrdata_q  <= '0;
      end else begin
         if (state == ST_LAST && !we_r) hrdata_q <= ram_dout;
         if (state == ST_WAIT) begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
               state     <= ST_LAST;
               hreadyout <= 1'b1;
            end
         end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            hreadyout <= 1'b1;
         end else if (acc) begin
            addr_r    <= ahb.HADDR[AW+BL-1:BL];
            we_r      <= ahb.HWRITE;
            be_r      <= BE_SIZE'(gen_be(ahb.HSIZE, ahb.HADDR[6:0], BE_SIZE));
            cnt       <= err ? 5'd0 : load;
            state     <= err ? ST_ERR1 : load == 5'd0 ? ST_LAST : ST_WAIT;
            hreadyout <= !err && load == 5'd0;
            hresp     <= err ? HRESP_ERROR : HRESP_OKAY;
         end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
         end
      end

   mpsoc_ram_1rw #(
      .ABITS(AW),
      .DEPTH(DEPTH),
      .DBITS(HDATA_SIZE),
      .TECHNOLOGY(TECHNOLOGY)
   ) u_ram (
      .clk_i (HCLK),
      .addr_i(addr_r),
      .we_i  (ram_we),
      .re_i  (ram_re),
      .be_i  (be_r),
      .din_i (ahb.HWDATA),
      .dout_o(ram_dout)
   );
endmodule
